// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for RV32I: sequences fetch/decode/execute/mem/writeback.
// Define RVSIMPLE_MC_TRAP_EN to trap illegal opcodes (adds TRAP state and trap port).
module multicycle_control_fsm #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [6:0]           inst_opcode,
   input  logic                 take_branch,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_addr_sel,
   output logic                 ir_write,
   output logic                 regfile_write,
   output logic [1:0]           reg_wr_sel,
   output logic                 alu_src_a,
   output logic                 alu_src_b,
   output logic [1:0]           alu_op_sel,
   output logic                 pc_write,
   output logic [1:0]           next_pc_sel,
   output logic                 retire,
`ifdef RVSIMPLE_MC_TRAP_EN
   output logic                 trap,
`endif
   output logic [INSTRET_W-1:0] instret,
   output logic [2:0]           state
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

`ifdef RVSIMPLE_MC_TRAP_EN
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4
   } state_e;
`endif

   state_e               state_q, state_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;

   logic is_load, is_store, is_branch, is_jal, is_jalr;
   logic is_op, is_op_imm, is_lui, is_auipc, is_wb;

   assign is_load   = (inst_opcode == OPC_LOAD);
   assign is_store  = (inst_opcode == OPC_STORE);
   assign is_branch = (inst_opcode == OPC_BRANCH);
   assign is_jal    = (inst_opcode == OPC_JAL);
   assign is_jalr   = (inst_opcode == OPC_JALR);
   assign is_op     = (inst_opcode == OPC_OP);
   assign is_op_imm = (inst_opcode == OPC_OP_IMM);
   assign is_lui    = (inst_opcode == OPC_LUI);
   assign is_auipc  = (inst_opcode == OPC_AUIPC);
   assign is_wb     = is_op | is_op_imm | is_lui | is_auipc | is_jal | is_jalr;

`ifdef RVSIMPLE_MC_TRAP_EN
   logic is_legal;
   assign is_legal = is_load | is_store | is_branch | is_wb
                   | (inst_opcode == OPC_FENCE)
                   | (inst_opcode == OPC_SYSTEM);
`endif

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_write      = 1'b0;
      regfile_write = 1'b0;
      reg_wr_sel    = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 1'b0;
      alu_op_sel    = 2'd0;
      pc_write      = 1'b0;
      next_pc_sel   = 2'd0;
      retire        = 1'b0;
`ifdef RVSIMPLE_MC_TRAP_EN
      trap          = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
`ifdef RVSIMPLE_MC_TRAP_EN
            state_d = is_legal ? S_EXECUTE : S_TRAP;
`else
            state_d = S_EXECUTE;
`endif
         end
         S_EXECUTE: begin
            unique case (1'b1)
               is_load, is_store: alu_src_b = 1'b1;
               is_branch: begin
                  alu_src_a  = 1'b1;
                  alu_src_b  = 1'b1;
                  alu_op_sel = 2'd1;
               end
               is_op: alu_op_sel = 2'd2;
               is_op_imm: begin
                  alu_src_b  = 1'b1;
                  alu_op_sel = 2'd2;
               end
               is_lui, is_jalr: alu_src_b = 1'b1;
               is_auipc, is_jal: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
               end
               default: begin end
            endcase
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_branch) begin
               pc_write    = 1'b1;
               next_pc_sel = take_branch ? 2'd1 : 2'd0;
               retire      = 1'b1;
               state_d     = S_FETCH;
            end else if (is_wb) begin
               state_d = S_WRITEBACK;
            end else begin
               // FENCE, SYSTEM and anything not trapped retire as a NOP
               pc_write = 1'b1;
               retire   = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: begin
            regfile_write = 1'b1;
            pc_write      = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
            unique case (1'b1)
               is_load:         reg_wr_sel = 2'd1;
               is_jal, is_jalr: reg_wr_sel = 2'd2;
               is_lui:          reg_wr_sel = 2'd3;
               default:         reg_wr_sel = 2'd0;
            endcase
            next_pc_sel = is_jal  ? 2'd1 :
                          is_jalr ? 2'd2 : 2'd0;
         end
`ifdef RVSIMPLE_MC_TRAP_EN
         S_TRAP: begin
            pc_write    = 1'b1;
            next_pc_sel = 2'd3;
            trap        = 1'b1;
            state_d     = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase
      // Reset is asynchronous: strobes must vanish before the next edge
      if (!reset_n) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         mem_addr_sel  = 1'b0;
         ir_write      = 1'b0;
         regfile_write = 1'b0;
         reg_wr_sel    = 2'd0;
         alu_src_a     = 1'b0;
         alu_src_b     = 1'b0;
         alu_op_sel    = 2'd0;
         pc_write      = 1'b0;
         next_pc_sel   = 2'd0;
         retire        = 1'b0;
`ifdef RVSIMPLE_MC_TRAP_EN
         trap          = 1'b0;
`endif
      end
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instruction streams
// checked against a transaction-level model of phases, strobes and instret.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

   localparam int W     = 8;
   localparam int TMO   = 30;
   localparam int K_LD  = 0;
   localparam int K_ST  = 1;
   localparam int K_BR  = 2;
   localparam int K_WB  = 3;
   localparam int K_NOP = 4;
   localparam int K_ILL = 5;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [6:0]   inst_opcode = 7'h00;
   logic         take_branch = 1'b0;
   logic         mem_ready = 1'b0;
   logic         mem_req, mem_we, mem_addr_sel, ir_write, regfile_write;
   logic [1:0]   reg_wr_sel, alu_op_sel, next_pc_sel;
   logic         alu_src_a, alu_src_b, pc_write, retire, trap_w;
   logic [W-1:0] instret;
   logic [2:0]   state;
   logic [16:0]  all_out;

   always #5 clock = ~clock;

   multicycle_control_fsm #(.INSTRET_W(W)) dut (
      .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode),
      .take_branch(take_branch), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .regfile_write(regfile_write),
      .reg_wr_sel(reg_wr_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
      .pc_write(pc_write), .next_pc_sel(next_pc_sel), .retire(retire),
`ifdef RVSIMPLE_MC_TRAP_EN
      .trap(trap_w),
`endif
      .instret(instret), .state(state)
   );

`ifndef RVSIMPLE_MC_TRAP_EN
   assign trap_w = 1'b0;
`endif

   assign all_out = {mem_req, mem_we, mem_addr_sel, ir_write, regfile_write,
                     reg_wr_sel, alu_src_a, alu_src_b, alu_op_sel, pc_write,
                     next_pc_sel, retire, trap_w};

   int n_cmp = 0;
   int n_bad = 0;
   int model_cnt = 0;

   int           o_cycles, o_wr, o_pc, o_ret, o_we, o_trap, o_ir, e_ret;
   logic [1:0]   o_wsel, o_npc;
   logic [3:0]   o_alu;
   logic         o_tb;
   logic [95:0]  o_seq;
   logic [W-1:0] o_instret;

   function automatic int kind_of(input logic [6:0] o);
      case (o)
         7'h03: return K_LD;
         7'h23: return K_ST;
         7'h63: return K_BR;
         7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67: return K_WB;
         7'h0f, 7'h73: return K_NOP;
`ifdef RVSIMPLE_MC_TRAP_EN
         default: return K_ILL;
`else
         default: return K_NOP;
`endif
      endcase
   endfunction

   // Expected state trace, one octal digit per cycle
   function automatic logic [95:0] model_seq(input int k, input int fw,
                                             input int dw);
      logic [95:0] s = '0;
      for (int i = 0; i <= fw; i++) s = {s[92:0], 3'd0};
      s = {s[92:0], 3'd1};
      if (k == K_ILL) return {s[92:0], 3'd5};
      s = {s[92:0], 3'd2};
      if (k == K_LD || k == K_ST)
         for (int i = 0; i <= dw; i++) s = {s[92:0], 3'd3};
      if (k == K_LD || k == K_WB) s = {s[92:0], 3'd4};
      return s;
   endfunction

   function automatic int model_cycles(input int k, input int fw,
                                       input int dw);
      int c = fw + 2;
      if (k == K_ILL) return c + 1;
      c = c + 1;
      if (k == K_LD || k == K_ST) c = c + dw + 1;
      if (k == K_LD || k == K_WB) c = c + 1;
      return c;
   endfunction

   function automatic logic [1:0] exp_wsel(input logic [6:0] o);
      if (o == 7'h03) return 2'd1;
      if (o == 7'h6f || o == 7'h67) return 2'd2;
      if (o == 7'h37) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [1:0] exp_npc(input logic [6:0] o,
                                          input logic tb);
      int k = kind_of(o);
      if (k == K_ILL) return 2'd3;
      if (k == K_BR) return {1'b0, tb};
      if (o == 7'h6f) return 2'd1;
      if (o == 7'h67) return 2'd2;
      return 2'd0;
   endfunction

   // {src_a, src_b, op} in EXECUTE where the ISA pins it; -1 = don't care
   function automatic int exp_alu(input logic [6:0] o);
      case (o)
         7'h03, 7'h23, 7'h67: return 4'b0100;
         7'h33:               return 4'b0010;
         7'h13:               return 4'b0110;
         7'h17, 7'h6f:        return 4'b1100;
         default:             return -1;
      endcase
   endfunction

   task automatic run_instr(input logic [6:0] opc, input int fw,
                            input int dw, input int take);
      int  k = kind_of(opc);
      bit  has_mem = (k == K_LD || k == K_ST);
      int  idx = 0;
      bit  done = 0;
      o_cycles = 0; o_wr = 0; o_pc = 0; o_ret = 0; o_we = 0;
      o_trap = 0; o_ir = 0; o_wsel = 2'd0; o_npc = 2'd0;
      o_alu = 4'd0; o_tb = 1'b0; o_seq = '0;
      while (!done) begin
         @(negedge clock);
         inst_opcode = (idx <= fw) ? 7'($urandom) : opc;
         mem_ready   = 1'($urandom);
         take_branch = 1'($urandom);
         if (idx <= fw) mem_ready = (idx == fw);
         if (has_mem && idx >= fw + 3 && idx <= fw + 3 + dw)
            mem_ready = (idx == fw + 3 + dw);
         if (idx == fw + 2) begin
            if (take >= 0) take_branch = take[0];
            o_tb = take_branch;
         end
         #1;
         o_seq = {o_seq[92:0], state};
         o_cycles++;
         if (idx == fw + 2) o_alu = {alu_src_a, alu_src_b, alu_op_sel};
         if (regfile_write) begin o_wr++; o_wsel = reg_wr_sel; end
         if (pc_write) begin o_pc++; o_npc = next_pc_sel; end
         if (retire) o_ret++;
         if (trap_w) o_trap++;
         if (mem_we) o_we++;
         if (ir_write) o_ir++;
         if (retire || trap_w || o_cycles >= TMO) done = 1;
         idx++;
      end
      n_cmp++;
      if (o_cycles >= TMO && o_ret == 0 && o_trap == 0) begin
         n_bad++;
         $display("FAIL timeout: opcode %h no retire/trap in %0d cycles",
                  opc, o_cycles);
      end
      e_ret = (k == K_ILL) ? 0 : 1;
      model_cnt += e_ret;
      @(posedge clock);
      #1;
      o_instret = instret;
   endtask

   task automatic test_reset;
      mem_ready = 1'b1; inst_opcode = 7'h03; take_branch = 1'b1;
      #2;
      n_cmp++;
      if (all_out !== '0 || state !== 3'd0 || instret !== '0) begin
         n_bad++;
         $display("FAIL reset_hold: out=%h state=%0d instret=%0d want 0",
                  all_out, state, instret);
      end
      repeat (2) @(negedge clock);
      mem_ready = 1'b0;
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (state !== 3'd0 || mem_req !== 1'b1 || instret !== '0) begin
         n_bad++;
         $display("FAIL reset_release: state=%0d req=%b instret=%0d want 0/1/0",
                  state, mem_req, instret);
      end
   endtask

   task automatic test_addi;
      run_instr(7'h13, 0, 0, -1);
      n_cmp++;
      if (o_seq !== 96'o0124 || o_cycles != 4) begin
         n_bad++;
         $display("FAIL addi_seq: got %o/%0d want 124/4", o_seq, o_cycles);
      end
      n_cmp++;
      if (o_wr != 1 || o_wsel !== 2'd0 || o_pc != 1 || o_npc !== 2'd0
          || o_instret !== 8'd1) begin
         n_bad++;
         $display("FAIL addi_wb: wr=%0d sel=%0d pc=%0d npc=%0d instret=%0d want 1/0/1/0/1",
                  o_wr, o_wsel, o_pc, o_npc, o_instret);
      end
   endtask

   task automatic test_lw;
      run_instr(7'h03, 3, 2, -1);
      n_cmp++;
      if (o_cycles != 10 || o_seq !== 96'o0000123334) begin
         n_bad++;
         $display("FAIL lw_seq: got %o/%0d want 123334/10", o_seq, o_cycles);
      end
      n_cmp++;
      if (o_wr != 1 || o_wsel !== 2'd1 || o_we != 0) begin
         n_bad++;
         $display("FAIL lw_wb: wr=%0d sel=%0d we=%0d want 1/1/0",
                  o_wr, o_wsel, o_we);
      end
   endtask

   task automatic test_branch;
      for (int t = 1; t >= 0; t--) begin
         run_instr(7'h63, 0, 0, t);
         n_cmp++;
         if (o_cycles != 3 || o_wr != 0 || o_pc != 1 || o_ret != 1
             || o_npc !== 2'(t)) begin
            n_bad++;
            $display("FAIL beq_take%0d: cyc=%0d wr=%0d pc=%0d ret=%0d npc=%0d want 3/0/1/1/%0d",
                     t, o_cycles, o_wr, o_pc, o_ret, o_npc, t);
         end
      end
   endtask

   task automatic test_jalr;
      run_instr(7'h67, 1, 0, -1);
      n_cmp++;
      if (o_cycles != 5 || o_wr != 1 || o_wsel !== 2'd2 || o_npc !== 2'd2)
      begin
         n_bad++;
         $display("FAIL jalr: cyc=%0d wr=%0d sel=%0d npc=%0d want 5/1/2/2",
                  o_cycles, o_wr, o_wsel, o_npc);
      end
   endtask

   task automatic test_illegal;
      run_instr(7'h7f, 0, 0, -1);
      n_cmp++;
`ifdef RVSIMPLE_MC_TRAP_EN
      if (o_trap != 1 || o_ret != 0 || o_npc !== 2'd3 || o_seq !== 96'o015
          || o_instret !== W'(model_cnt)) begin
         n_bad++;
         $display("FAIL illegal_trap: trap=%0d ret=%0d npc=%0d seq=%o instret=%0d",
                  o_trap, o_ret, o_npc, o_seq, o_instret);
      end
`else
      if (o_ret != 1 || o_wr != 0 || o_npc !== 2'd0 || o_seq !== 96'o012
          || o_instret !== W'(model_cnt)) begin
         n_bad++;
         $display("FAIL illegal_nop: ret=%0d wr=%0d npc=%0d seq=%o instret=%0d",
                  o_ret, o_wr, o_npc, o_seq, o_instret);
      end
`endif
   endtask

   task automatic test_random;
      logic [6:0] tab [11] = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h37,
                               7'h17, 7'h6f, 7'h67, 7'h0f, 7'h73};
      for (int n = 0; n < 150; n++) begin
         int         sel = $urandom_range(0, 11);
         logic [6:0] opc = (sel == 11) ? 7'($urandom) : tab[sel];
         int         fw  = $urandom_range(0, 3);
         int         dw  = $urandom_range(0, 3);
         int         k   = kind_of(opc);
         int         ea  = exp_alu(opc);
         int         ewr = (k == K_LD || k == K_WB) ? 1 : 0;
         int         ewe = (k == K_ST) ? dw + 1 : 0;
         run_instr(opc, fw, dw, -1);
         n_cmp++;
         if (o_seq !== model_seq(k, fw, dw)
             || o_cycles != model_cycles(k, fw, dw)) begin
            n_bad++;
            $display("FAIL rnd_seq: op=%h got %o/%0d want %o/%0d", opc,
                     o_seq, o_cycles, model_seq(k, fw, dw),
                     model_cycles(k, fw, dw));
         end
         n_cmp++;
         if (o_wr != ewr || o_wsel !== exp_wsel(opc) || o_we != ewe
             || o_ir != 1) begin
            n_bad++;
            $display("FAIL rnd_strobe: op=%h wr=%0d sel=%0d we=%0d ir=%0d want %0d/%0d/%0d/1",
                     opc, o_wr, o_wsel, o_we, o_ir, ewr, exp_wsel(opc), ewe);
         end
         n_cmp++;
         if (o_pc != 1 || o_npc !== exp_npc(opc, o_tb)
             || o_ret != e_ret || o_trap != 1 - e_ret) begin
            n_bad++;
            $display("FAIL rnd_pc: op=%h pc=%0d npc=%0d ret=%0d trap=%0d want 1/%0d/%0d/%0d",
                     opc, o_pc, o_npc, o_ret, o_trap, exp_npc(opc, o_tb),
                     e_ret, 1 - e_ret);
         end
         n_cmp++;
         if ((ea >= 0 && o_alu !== 4'(ea)) || o_instret !== W'(model_cnt))
         begin
            n_bad++;
            $display("FAIL rnd_alu_cnt: op=%h alu=%b want %0d instret=%0d want %0d",
                     opc, o_alu, ea, o_instret, W'(model_cnt));
         end
      end
   endtask

   task automatic test_wrap;
      while (W'(model_cnt) != 8'hff) run_instr(7'h0f, 0, 0, -1);
      n_cmp++;
      if (instret !== 8'hff) begin
         n_bad++;
         $display("FAIL wrap_pre: instret=%0d want 255", instret);
      end
      run_instr(7'h0f, 0, 0, -1);
      n_cmp++;
      if (o_instret !== 8'h00 || o_ret != 1) begin
         n_bad++;
         $display("FAIL wrap: instret=%0d ret=%0d want 0/1", o_instret, o_ret);
      end
   endtask

   task automatic test_mid_reset;
      @(negedge clock);
      inst_opcode = 7'h23; mem_ready = 1'b1; take_branch = 1'b0;
      @(negedge clock);
      mem_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr_sel !== 1'b1
          || state !== 3'd3) begin
         n_bad++;
         $display("FAIL store_mem: req=%b we=%b sel=%b state=%0d want 1/1/1/3",
                  mem_req, mem_we, mem_addr_sel, state);
      end
      #1;
      reset_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (all_out !== '0 || state !== 3'd0 || instret !== '0) begin
         n_bad++;
         $display("FAIL midreset: out=%h state=%0d instret=%0d want 0",
                  all_out, state, instret);
      end
      @(negedge clock);
      mem_ready = 1'b0;
      reset_n = 1'b1;
      model_cnt = 0;
      #1;
      n_cmp++;
      if (state !== 3'd0 || mem_req !== 1'b1 || instret !== '0) begin
         n_bad++;
         $display("FAIL midreset_release: state=%0d req=%b instret=%0d want 0/1/0",
                  state, mem_req, instret);
      end
      run_instr(7'h33, 0, 0, -1);
      n_cmp++;
      if (o_instret !== 8'd1 || o_seq !== 96'o0124) begin
         n_bad++;
         $display("FAIL post_reset_op: instret=%0d seq=%o want 1/124",
                  o_instret, o_seq);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw();
      test_branch();
      test_jalr();
      test_illegal();
      test_random();
      test_wrap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
